// File: rtl/addsub_acc_pkg.sv
// ============================================================================
// addsub_acc_pkg : shared FSM state type and signed range helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package addsub_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic longint acc_max(input int acc_w);
    return (longint'(1) << (acc_w - 1)) - longint'(1);
  endfunction

  function automatic longint acc_min(input int acc_w);
    return -(longint'(1) << (acc_w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_block_accumulator_if.sv
// ============================================================================
// addsub_block_accumulator_if : input beat and block-total handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface addsub_block_accumulator_if #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

`default_nettype wire

// File: rtl/addsub_sat_unit.sv
// ============================================================================
// addsub_sat_unit : one signed add/subtract step with overflow detection;
// clamps on overflow when ADDSUB_ACC_SATURATE_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module addsub_sat_unit
  import addsub_acc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_operand,
  input  logic             i_sub,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  logic [ACC_W-1:0] w_raw;
  logic             w_ovf;
  logic             w_sign_a;
  logic             w_sign_b;
  logic             w_sign_r;

  assign w_raw    = i_sub ? (i_acc - i_operand) : (i_acc + i_operand);
  assign w_sign_a = i_acc[ACC_W-1];
  assign w_sign_b = i_operand[ACC_W-1];
  assign w_sign_r = w_raw[ACC_W-1];

  // Subtraction overflows only when operand signs differ; addition only when they match.
  assign w_ovf = i_sub ? ((w_sign_a != w_sign_b) && (w_sign_r != w_sign_a))
                       : ((w_sign_a == w_sign_b) && (w_sign_r != w_sign_a));

`ifdef ADDSUB_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] C_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] C_MIN = ACC_W'(acc_min(ACC_W));

  // On overflow the true result always carries the sign of the accumulator.
  assign o_acc = w_ovf ? (w_sign_a ? C_MIN : C_MAX) : w_raw;
`else
  assign o_acc = w_raw;
`endif

  assign o_ovf = w_ovf;

endmodule

`default_nettype wire

// File: rtl/addsub_block_accumulator.sv
// ============================================================================
// addsub_block_accumulator : folds BLOCK_LEN add/sub beats into a signed total
// with sticky overflow; option macro ADDSUB_ACC_SATURATE_EN. Rev 1.0
// ============================================================================
`default_nettype none

module addsub_block_accumulator
  import addsub_acc_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  addsub_block_accumulator_if.slave   bus
);

  localparam int               CNT_W  = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BLOCK_LEN);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_beat;
  logic             w_take;
  logic             w_last;
  logic [ACC_W-1:0] w_operand;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ovf_step;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_operand  = {{(ACC_W-IN_W){1'b0}}, bus.in_data};
  // A block always starts from zero, regardless of what r_acc last held.
  assign w_acc_base = (r_state == IDLE) ? '0 : r_acc;
  assign w_cnt_nxt  = (r_state == IDLE) ? C_ONE : (r_cnt + C_ONE);
  assign w_last     = (w_cnt_nxt == C_LAST);
  assign w_beat     = bus.in_valid & w_in_ready;
  assign w_take     = w_out_valid & bus.out_ready;

  addsub_sat_unit #(
    .ACC_W (ACC_W)
  ) u_sat_unit (
    .i_acc     (w_acc_base),
    .i_operand (w_operand),
    .i_sub     (bus.in_sub),
    .o_acc     (w_acc_nxt),
    .o_ovf     (w_ovf_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs depend on r_state alone, never on in_valid/out_ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = w_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_take) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= r_ovf | w_ovf_step;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_acc;
  assign bus.out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_addsub_block_accumulator.sv
// ============================================================================
// tb_addsub_block_accumulator : vector table, corner sequences and random blocks
// against an integer reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_addsub_block_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_block_accumulator_if #(.IN_W(4), .ACC_W(8)) bus_a ();
  addsub_block_accumulator_if #(.IN_W(4), .ACC_W(8)) bus_b ();
  addsub_block_accumulator_if #(.IN_W(4), .ACC_W(8)) bus_c ();

  addsub_block_accumulator #(.IN_W(4), .ACC_W(8), .BLOCK_LEN(4)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  addsub_block_accumulator #(.IN_W(4), .ACC_W(8), .BLOCK_LEN(9)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );
  addsub_block_accumulator #(.IN_W(4), .ACC_W(8), .BLOCK_LEN(1)) u_dut_c (
    .clk (clk), .rst_n (rst_n), .bus (bus_c)
  );

`ifdef ADDSUB_ACC_SATURATE_EN
  localparam logic [7:0] C_B135 = 8'h7F;
`else
  localparam logic [7:0] C_B135 = 8'h87;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  s;
    logic [7:0]  ed;
    logic        eo;
  } vec_t;

  vec_t       vecs [6];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         steps [16];
  logic [8:0] exp_r;
  logic [3:0] rd;
  logic       rs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Signed sum of the steps, clamped or wrapped into the 8-bit range.
  function automatic logic [8:0] model(input int st [16], input int n);
    int   acc;
    int   t;
    logic ovf;
    acc = 0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = acc + st[i];
      if (t > 127 || t < -128) begin
        ovf = 1'b1;
`ifdef ADDSUB_ACC_SATURATE_EN
        acc = (t > 127) ? 127 : -128;
`else
        acc = (t > 127) ? t - 256 : t + 256;
`endif
      end else begin
        acc = t;
      end
    end
    return {ovf, acc[7:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat_a(input logic [3:0] d, input logic s);
    chk("a in_ready before beat", 32'(bus_a.in_ready), 32'd1);
    bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_sub = s;
    cyc();
    bus_a.in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [3:0] d, input logic s);
    chk("b in_ready before beat", 32'(bus_b.in_ready), 32'd1);
    bus_b.in_valid = 1'b1; bus_b.in_data = d; bus_b.in_sub = s;
    cyc();
    bus_b.in_valid = 1'b0;
  endtask

  task automatic beat_c(input logic [3:0] d, input logic s);
    chk("c in_ready before beat", 32'(bus_c.in_ready), 32'd1);
    bus_c.in_valid = 1'b1; bus_c.in_data = d; bus_c.in_sub = s;
    cyc();
    bus_c.in_valid = 1'b0;
  endtask

  task automatic expect_a(input string nm, input logic [7:0] ed, input logic eo, input int hold);
    chk({nm, " out_valid"}, 32'(bus_a.out_valid), 32'd1);
    chk({nm, " out_data"}, 32'(bus_a.out_data), 32'(ed));
    chk({nm, " out_ovf"}, 32'(bus_a.out_ovf), 32'(eo));
    chk({nm, " in_ready in hold"}, 32'(bus_a.in_ready), 32'd0);
    bus_a.out_ready = 1'b0;
    repeat (hold) begin
      cyc();
      chk({nm, " held data"}, 32'({bus_a.out_valid, bus_a.out_ovf, bus_a.out_data}),
          32'({1'b1, eo, ed}));
    end
    bus_a.out_ready = 1'b1;
    cyc();
    bus_a.out_ready = 1'b0;
    chk({nm, " released"}, 32'({bus_a.in_ready, bus_a.out_valid}), 32'(2'b10));
  endtask

  task automatic expect_b(input string nm, input logic [7:0] ed, input logic eo);
    chk({nm, " result"}, 32'({bus_b.out_valid, bus_b.in_ready, bus_b.out_ovf, bus_b.out_data}),
        32'({1'b1, 1'b0, eo, ed}));
    bus_b.out_ready = 1'b1;
    cyc();
    bus_b.out_ready = 1'b0;
    chk({nm, " released"}, 32'({bus_b.in_ready, bus_b.out_valid}), 32'(2'b10));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("a ready/valid exclusive", 32'(bus_a.in_ready & bus_a.out_valid), 32'd0);
      chk("b ready/valid exclusive", 32'(bus_b.in_ready & bus_b.out_valid), 32'd0);
      chk("c ready/valid exclusive", 32'(bus_c.in_ready & bus_c.out_valid), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1753, 4'b0000, 8'h10, 1'b0};
    vecs[1] = '{16'h12F9, 4'b1010, 8'hFB, 1'b0};
    vecs[2] = '{16'hFFFF, 4'b0000, 8'h3C, 1'b0};
    vecs[3] = '{16'hFFFF, 4'b1111, 8'hC4, 1'b0};
    vecs[4] = '{16'h0000, 4'b0101, 8'h00, 1'b0};
    vecs[5] = '{16'h0F88, 4'b0010, 8'h0F, 1'b0};

    {bus_a.in_valid, bus_a.in_data, bus_a.in_sub, bus_a.out_ready} = '0;
    {bus_b.in_valid, bus_b.in_data, bus_b.in_sub, bus_b.out_ready} = '0;
    {bus_c.in_valid, bus_c.in_data, bus_c.in_sub, bus_c.out_ready} = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("a reset state", 32'({bus_a.in_ready, bus_a.out_valid, bus_a.out_ovf, bus_a.out_data}),
        32'({1'b1, 1'b0, 1'b0, 8'h00}));
    chk("b reset state", 32'({bus_b.in_ready, bus_b.out_valid}), 32'(2'b10));
    chk("c reset state", 32'({bus_c.in_ready, bus_c.out_valid}), 32'(2'b10));
    rst_n = 1'b1;
    cyc();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        beat_a(vecs[v].d[4*i +: 4], vecs[v].s[i]);
      end
      expect_a($sformatf("vec%0d", v), vecs[v].ed, vecs[v].eo, 0);
    end

    // Backpressure: a beat offered during HOLD must not be counted.
    beat_a(4'd1, 1'b0); beat_a(4'd2, 1'b0); beat_a(4'd3, 1'b0); beat_a(4'd4, 1'b0);
    chk("bp total", 32'(bus_a.out_data), 32'h0A);
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'd7; bus_a.in_sub = 1'b0;
    repeat (5) begin
      cyc();
      chk("bp stalled", 32'({bus_a.out_valid, bus_a.in_ready, bus_a.out_data}),
          32'({1'b1, 1'b0, 8'h0A}));
    end
    bus_a.out_ready = 1'b1;
    cyc();
    bus_a.out_ready = 1'b0;
    chk("bp released", 32'({bus_a.in_ready, bus_a.out_valid}), 32'(2'b10));
    repeat (4) cyc();
    bus_a.in_valid = 1'b0;
    expect_a("bp next block", 8'h1C, 1'b0, 0);

    // Reset in mid-block discards the partial total.
    beat_a(4'd2, 1'b0); beat_a(4'd4, 1'b0);
    rst_n = 1'b0;
    cyc();
    chk("abort state", 32'({bus_a.in_ready, bus_a.out_valid, bus_a.out_data}),
        32'({1'b1, 1'b0, 8'h00}));
    rst_n = 1'b1;
    cyc();
    chk("abort no output", 32'(bus_a.out_valid), 32'd0);
    repeat (4) beat_a(4'd1, 1'b0);
    expect_a("after abort", 8'h04, 1'b0, 0);

    // Nine-beat block overflowing at 135, then a fresh block clears the flag.
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("b not yet valid", 32'(bus_b.out_valid), 32'd0);
      beat_b(4'd15, 1'b0);
    end
    expect_b("b 9x15", C_B135, 1'b1);
    beat_b(4'd15, 1'b1);
    repeat (8) beat_b(4'd0, 1'b0);
    expect_b("b minus15", 8'hF1, 1'b0);

    // Single-beat blocks.
    beat_c(4'd6, 1'b0);
    chk("c first", 32'({bus_c.out_valid, bus_c.in_ready, bus_c.out_data}), 32'({2'b10, 8'h06}));
    bus_c.out_ready = 1'b1;
    cyc();
    chk("c released", 32'({bus_c.in_ready, bus_c.out_valid}), 32'(2'b10));
    beat_c(4'd3, 1'b1);
    chk("c second", 32'({bus_c.out_valid, bus_c.in_ready, bus_c.out_data}), 32'({2'b10, 8'hFD}));
    cyc();
    bus_c.out_ready = 1'b0;

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) begin
          bus_a.in_data = 4'($urandom);
          cyc();
        end
        rd = 4'($urandom);
        rs = 1'($urandom);
        steps[i] = rs ? -int'(rd) : int'(rd);
        beat_a(rd, rs);
      end
      exp_r = model(steps, 4);
      expect_a("rand a", exp_r[7:0], exp_r[8], int'($urandom_range(0, 3)));
    end

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 9; i++) begin
        rd = 4'($urandom);
        rs = ($urandom_range(0, 3) == 0);
        steps[i] = rs ? -int'(rd) : int'(rd);
        beat_b(rd, rs);
      end
      exp_r = model(steps, 9);
      expect_b("rand b", exp_r[7:0], exp_r[8]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/addsub_block_accumulator.md
# addsub_block_accumulator

Downstream stage for the 4-bit add/subtract datapath. Takes a stream of unsigned operand results, each tagged add or subtract, over a valid/ready handshake. Folds each group of BLOCK_LEN beats into a signed two's-complement accumulator. Presents the block total, with a sticky overflow flag, on a second valid/ready port.

## Interface
- IN_W, 4, width of incoming unsigned result
- ACC_W, 8, accumulator/output width, signed; must exceed IN_W
- BLOCK_LEN, 4, beats per block, ≥1
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_data  in  IN_W  unsigned operand
- in_sub  in  1  1: subtract in_data, 0: add
- out_valid  out  1  block total available
- out_ready  in  1  consumer takes total
- out_data  out  ACC_W  signed block total
- out_ovf  out  1  signed overflow occurred at any beat in block

## Operation
- Beat accepted when in_valid & in_ready on a rising edge; output taken when out_valid & out_ready.
- operand = zero-extend(in_data) to ACC_W; applied as acc ± operand.
- FSM states:
  - IDLE: acc=0, cnt=0, ovf=0, in_ready=1. An accepted beat loads acc=±operand and cnt=1. It then goes to ACCUM, or to HOLD if BLOCK_LEN==1.
  - ACCUM: in_ready=1. Each accepted beat updates acc and increments cnt. The beat making cnt==BLOCK_LEN moves to HOLD.
  - HOLD: in_ready=0, out_valid=1, out_data=acc, out_ovf=ovf. A handshake returns to IDLE.
- Overflow: signed overflow of the ACC_W add/sub sets ovf. ovf stays set until the block is consumed.
- Without saturation, acc wraps modulo 2^ACC_W.
- in_valid with in_ready=0 is ignored; the upstream must hold its data.
- out_data and out_ovf are stable while out_valid=1 and out_ready=0.
- in_sub is sampled only on accepted beats.

## Timing
- Reset values: out_valid=0, out_data=0, out_ovf=0, in_ready=1 (IDLE), acc=0, cnt=0.
- Reset mid-block or in HOLD aborts immediately; the partial total is discarded and never presented.
- Latency: out_valid rises the cycle after the BLOCK_LEN-th beat is accepted.
- Throughput: one beat per cycle within a block. There is one bubble cycle per block: HOLD, then IDLE, with in_ready high the cycle after the output handshake.
- out_valid and in_ready are never both 1.
- out_data and out_ovf are registered; in_ready and out_valid decode from the state register only, with no combinational path from in_valid or out_ready.
- cnt width is clog2(BLOCK_LEN+1); cnt never exceeds BLOCK_LEN.

## Configuration
- ADDSUB_ACC_SATURATE_EN defined: on overflow, acc clamps to the signed max (2^(ACC_W-1)-1) or min (-2^(ACC_W-1)) and later beats continue from the clamped value. ovf is still set.
- ADDSUB_ACC_SATURATE_EN not defined: acc wraps. ovf is set identically.

## Structure
- Package addsub_acc_pkg holds:
  - state enum (IDLE, ACCUM, HOLD)
  - ACC_MAX/ACC_MIN constant functions of ACC_W
- Sub-module addsub_sat_unit: combinational. Takes acc, operand and sub; returns next acc and an overflow bit. Saturation logic lives inside it under the macro.
- The top level holds the FSM, cnt, the registers and the handshakes.

## Test plan
- Defaults, add beats 3,5,7,1 back-to-back → out_valid the cycle after beat 4, out_data=8'h10, out_ovf=0. in_ready low exactly one HOLD cycle when out_ready=1.
- +9, −15, +2, −1 → out_data=8'hFB (−5), out_ovf=0.
- BLOCK_LEN=9, add 15 nine times (135):
  - without macro → out_data=8'h87, out_ovf=1
  - with ADDSUB_ACC_SATURATE_EN → 8'h7F, out_ovf=1
  - then −15 in next block → 8'hF1, out_ovf=0 (flag cleared)
- Backpressure: out_ready low 5 cycles in HOLD while in_valid=1 with data 7 → out_data stable, in_ready=0, no beat counted. The next block sums only beats presented after release.
- Assert rst_n low after 2 beats (2,4), release, send 1,1,1,1 → no output for the aborted block, then out_data=8'h04.
- BLOCK_LEN=1, beats 6 then sub 3 with out_ready=1 → outputs 8'h06 then 8'hFD, each one cycle after acceptance.
